dmem_arbiter: RTL

- Shares the single-port 256-byte data memory between two requesters: port 0 (core load/store) and port 1 (loader/DMA).
- Each requester sees a valid/ready request channel plus a one-cycle-latency read response.
- Arbitration is round-robin or fixed-priority, with an optional lock for atomic read-modify-write sequences.
- Sits between the requesters and the data memory; it is the only driver of the memory's mem_read, mem_write, address and write-data inputs.

---
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port 256-byte data memory.
// Round-robin or fixed-priority grant, optional lock for read-modify-write.
module dmem_arbiter #(
   parameter int RR_EN    = 1,
   parameter int LOCK_MAX = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic       req0_write,
   input  logic       req0_lock,
   input  logic [7:0] req0_addr,
   input  logic [7:0] req0_wdata,
   output logic       req0_ready,
   output logic       rsp0_valid,
   output logic [7:0] rsp0_rdata,
   input  logic       req1_valid,
   input  logic       req1_write,
   input  logic       req1_lock,
   input  logic [7:0] req1_addr,
   input  logic [7:0] req1_wdata,
   output logic       req1_ready,
   output logic       rsp1_valid,
   output logic [7:0] rsp1_rdata,
   output logic       mem_read,
   output logic       mem_write,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   output logic       lock_timeout
);

   // state       | meaning
   // ST_UNLOCKED | normal arbitration between both ports
   // ST_LOCKED   | only lock_owner may be granted; lock_cnt ages the lock
   typedef enum logic {ST_UNLOCKED, ST_LOCKED} lock_state_t;

   localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

   lock_state_t state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        lock_owner_q, lock_owner_d;
   logic [7:0]  lock_cnt_q, lock_cnt_d;
   logic        lock_timeout_q, lock_timeout_d;
   logic        rsp0_valid_q, rsp0_valid_d;
   logic        rsp1_valid_q, rsp1_valid_d;
   logic [7:0]  rsp0_rdata_q, rsp0_rdata_d;
   logic [7:0]  rsp1_rdata_q, rsp1_rdata_d;

   logic gnt_valid;
   logic gnt_port;
   logic acc_write;
   logic acc_lock;

   // No grant while reset is held, so the memory side reads all-zero in reset.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_port  = 1'b0;
      if (reset) begin
         if (state_q == ST_LOCKED) begin
            gnt_port  = lock_owner_q;
            gnt_valid = lock_owner_q ? req1_valid : req0_valid;
         end else if (req0_valid && req1_valid) begin
            gnt_valid = 1'b1;
            gnt_port  = (RR_EN != 0) ? ~last_grant_q : 1'b0;
         end else if (req0_valid) begin
            gnt_valid = 1'b1;
         end else if (req1_valid) begin
            gnt_valid = 1'b1;
            gnt_port  = 1'b1;
         end
      end
   end

   assign acc_write  = gnt_port ? req1_write : req0_write;
   assign acc_lock   = gnt_port ? req1_lock  : req0_lock;

   assign req0_ready = gnt_valid & ~gnt_port;
   assign req1_ready = gnt_valid &  gnt_port;
   assign mem_write  = gnt_valid &  acc_write;
   assign mem_read   = gnt_valid & ~acc_write;
   assign mem_addr   = gnt_valid ? (gnt_port ? req1_addr  : req0_addr)  : 8'h00;
   assign mem_wdata  = gnt_valid ? (gnt_port ? req1_wdata : req0_wdata) : 8'h00;

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      lock_owner_d   = lock_owner_q;
      lock_cnt_d     = lock_cnt_q;
      lock_timeout_d = 1'b0;
      rsp0_valid_d   = 1'b0;
      rsp1_valid_d   = 1'b0;
      rsp0_rdata_d   = rsp0_rdata_q;
      rsp1_rdata_d   = rsp1_rdata_q;

      if (mem_read && !gnt_port) begin
         rsp0_valid_d = 1'b1;
         rsp0_rdata_d = mem_rdata;
      end
      if (mem_read && gnt_port) begin
         rsp1_valid_d = 1'b1;
         rsp1_rdata_d = mem_rdata;
      end
      if (gnt_valid) begin
         last_grant_d = gnt_port;
      end

      case (state_q)
         ST_UNLOCKED: begin
            if (gnt_valid && acc_lock) begin
               state_d      = ST_LOCKED;
               lock_owner_d = gnt_port;
               lock_cnt_d   = 8'd0;
            end
         end
         ST_LOCKED: begin
            lock_cnt_d = lock_cnt_q + 8'd1;
            // Forced release wins even if the owner re-locks on the same edge.
            if (lock_cnt_q == CNT_LAST) begin
               state_d        = ST_UNLOCKED;
               lock_timeout_d = 1'b1;
               last_grant_d   = lock_owner_q;
               lock_cnt_d     = 8'd0;
            end else if (gnt_valid && !acc_lock) begin
               state_d      = ST_UNLOCKED;
               last_grant_d = lock_owner_q;
               lock_cnt_d   = 8'd0;
            end
         end
         default: state_d = ST_UNLOCKED;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_UNLOCKED;
         last_grant_q   <= 1'b1;
         lock_owner_q   <= 1'b0;
         lock_cnt_q     <= 8'd0;
         lock_timeout_q <= 1'b0;
         rsp0_valid_q   <= 1'b0;
         rsp1_valid_q   <= 1'b0;
         rsp0_rdata_q   <= 8'h00;
         rsp1_rdata_q   <= 8'h00;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         lock_owner_q   <= lock_owner_d;
         lock_cnt_q     <= lock_cnt_d;
         lock_timeout_q <= lock_timeout_d;
         rsp0_valid_q   <= rsp0_valid_d;
         rsp1_valid_q   <= rsp1_valid_d;
         rsp0_rdata_q   <= rsp0_rdata_d;
         rsp1_rdata_q   <= rsp1_rdata_d;
      end
   end

   assign rsp0_valid   = rsp0_valid_q;
   assign rsp1_valid   = rsp1_valid_q;
   assign rsp0_rdata   = rsp0_rdata_q;
   assign rsp1_rdata   = rsp1_rdata_q;
   assign lock_timeout = lock_timeout_q;

endmodule
